// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB3 register bank with wait states, decode errors and read-only slots.
// Define APB_PSTRB_EN to add the APB4 PSTRB port and byte-lane writes.
module apb_slave_regbank #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int N_REGS = 8,
  parameter int WAIT_STATES = 0,
  parameter logic [N_REGS-1:0] RO_MASK = '0
) (
  input  logic                               PCLK,
  input  logic                               PRESET,
  input  logic [APB_ADDR_WIDTH-1:0]          PADDR,
  input  logic                               PSEL,
  input  logic                               PENABLE,
  input  logic                               PWRITE,
  input  logic [APB_DATA_WIDTH-1:0]          PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [APB_DATA_WIDTH/8-1:0]        PSTRB,
`endif
  output logic                               PREADY,
  output logic [APB_DATA_WIDTH-1:0]          PRDATA,
  output logic                               PSLVERR,
  input  logic [N_REGS*APB_DATA_WIDTH-1:0]   ro_val,
  output logic [N_REGS*APB_DATA_WIDTH-1:0]   reg_q,
  output logic [N_REGS-1:0]                  reg_wr
);
  localparam int DW = APB_DATA_WIDTH;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [N_REGS-1:0][DW-1:0] regs;
  logic [31:0] idx;
  logic err, ready;
  logic [DW-1:0] rdata, wmask;
  logic [N_REGS-1:0] hit, we;
  assign idx = 32'(PADDR[APB_ADDR_WIDTH-1:2]);
  assign err = PADDR[1:0] != 2'b00 || idx >= 32'(N_REGS);
  assign ready = state == ACCESS && cnt == 4'd0 && PSEL;
  assign PREADY = ready;
  assign PSLVERR = ready && err;
  assign PRDATA = ready && !err ? rdata : '0;
  assign reg_q = regs;
  always_comb begin
    rdata = '0;
    hit = '0;
    we = '0;
    for (int i = 0; i < N_REGS; i++) begin
      hit[i] = idx == 32'(i);
      we[i] = ready && PWRITE && !err && hit[i] && !RO_MASK[i];
      if (hit[i]) rdata = RO_MASK[i] ? ro_val[i*DW +: DW] : regs[i];
    end
  end
`ifdef APB_PSTRB_EN
  always_comb begin
    wmask = '0;
    for (int b = 0; b < DW/8; b++) wmask[b*8 +: 8] = {8{PSTRB[b]}};
  end
`else
  assign wmask = '1;
`endif
  // Setup phase is decoded straight from IDLE, so PREADY can rise in the first PENABLE cycle.
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = PSEL && !PENABLE ? ACCESS : IDLE;
    else if (!PSEL || ready) state_n = IDLE;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt <= '0;
      regs <= '0;
      reg_wr <= '0;
    end else begin
      state <= state_n;
      cnt <= state == IDLE ? 4'(WAIT_STATES) : cnt != 4'd0 ? cnt - 4'd1 : cnt;
      reg_wr <= we;
      for (int i = 0; i < N_REGS; i++)
        if (we[i]) regs[i] <= (regs[i] & ~wmask) | (PWDATA & wmask);
    end
  end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: directed bench over three instances (0, 3 and 4 wait states) with a response scoreboard.
module tb_apb_slave_regbank;
  typedef struct {logic [31:0] rdata; logic err; int waits;} exp_t;
  logic PCLK = 1'b0, PRESET = 1'b1, penable = 1'b0, pwrite = 1'b0;
  logic [2:0] psel = '0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0] pstrb = 4'hF;
  logic [255:0] ro_val;
  logic [2:0] pready, pslverr;
  logic [31:0] prdata [3];
  logic [255:0] reg_q [3];
  logic [7:0] reg_wr [3];
  logic [255:0] m0;
  logic [7:0] acc;
  logic [2:0] rdy_acc;
  exp_t sb[$];
  int tests = 0, fails = 0;

  always #5 PCLK = ~PCLK;

  initial begin
    ro_val = {8{32'hA5A5A5A5}};
    ro_val[95:64] = 32'h12345678;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_regbank #(
      .WAIT_STATES(g == 0 ? 0 : g == 1 ? 3 : 4),
      .RO_MASK(g == 0 ? 8'h04 : 8'h00)
    ) u_dut (
      .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PSEL(psel[g]),
      .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
      .PSTRB(pstrb),
`endif
      .PREADY(pready[g]), .PRDATA(prdata[g]), .PSLVERR(pslverr[g]),
      .ro_val(ro_val), .reg_q(reg_q[g]), .reg_wr(reg_wr[g])
    );
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int d, input bit wr, input logic [11:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr, input int ew, input string tag);
    exp_t e;
    int n;
    sb.push_back('{rdata: erd, err: eerr, waits: ew});
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge PCLK); #1;
    penable = 1'b1;
    n = 0;
    @(negedge PCLK);
    while (!pready[d] && n < 40) begin
      n++;
      @(negedge PCLK);
    end
    e = sb.pop_front();
    chk({tag, "_ready"}, 256'(pready[d]), 256'(1));
    chk({tag, "_waits"}, 256'(n), 256'(e.waits));
    chk({tag, "_err"}, 256'(pslverr[d]), 256'(e.err));
    if (!wr) chk({tag, "_rdata"}, 256'(prdata[d]), 256'(e.rdata));
    @(posedge PCLK); #1;
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    m0 = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_regq%0d", d), reg_q[d], '0);
      chk($sformatf("rst_wr%0d", d), 256'(reg_wr[d]), '0);
    end
    chk("rst_ready", 256'(pready), '0);
    chk("rst_prdata", 256'(prdata[0]), '0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    xfer(0, 1, 12'h004, 32'hDEADBEEF, 0, 0, 0, "w0_wr");
    m0[63:32] = 32'hDEADBEEF;
    @(negedge PCLK);
    chk("w0_pulse", 256'(reg_wr[0]), 256'(8'h02));
    @(negedge PCLK);
    chk("w0_pulse_end", 256'(reg_wr[0]), '0);
    chk("w0_regq", reg_q[0], m0);
    @(posedge PCLK); #1;
    xfer(0, 0, 12'h004, 0, 32'hDEADBEEF, 0, 0, "w0_rd");
    xfer(0, 1, 12'h01C, 32'h0BADF00D, 0, 0, 0, "w0_wr7");
    m0[255:224] = 32'h0BADF00D;
    xfer(0, 0, 12'h01C, 0, 32'h0BADF00D, 0, 0, "w0_rd7");

    xfer(1, 0, 12'h000, 0, 32'h0, 0, 3, "w3_rd");

    xfer(0, 1, 12'h020, 32'h11111111, 0, 1, 0, "err_wr");
    @(negedge PCLK);
    chk("err_wr_nopulse", 256'(reg_wr[0]), '0);
    chk("err_wr_regq", reg_q[0], m0);
    @(posedge PCLK); #1;
    xfer(0, 0, 12'h002, 0, 32'h0, 1, 0, "err_rd");

    xfer(0, 1, 12'h008, 32'hFFFFFFFF, 0, 0, 0, "ro_wr");
    @(negedge PCLK);
    chk("ro_nopulse", 256'(reg_wr[0]), '0);
    chk("ro_regq", reg_q[0], m0);
    @(posedge PCLK); #1;
    xfer(0, 0, 12'h008, 0, 32'h12345678, 0, 0, "ro_rd");

    xfer(2, 1, 12'h00C, 32'h00000055, 0, 0, 4, "w4_wr");
    xfer(2, 0, 12'h00C, 0, 32'h00000055, 0, 4, "w4_rd");

    psel[2] = 1'b1; pwrite = 1'b1; paddr = 12'h00C; pwdata = 32'h000000AA;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    psel[2] = 1'b0; penable = 1'b0;
    acc = '0; rdy_acc = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK);
      acc |= reg_wr[2];
      rdy_acc |= pready;
    end
    chk("viol_nopulse", 256'(acc), '0);
    chk("viol_noready", 256'(rdy_acc), '0);
    chk("viol_regq", 256'(reg_q[2][127:96]), 256'(32'h00000055));

    @(posedge PCLK); #1;
    psel[2] = 1'b1; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h99999999;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    m0 = '0;
    acc = '0; rdy_acc = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge PCLK);
      acc |= reg_wr[2];
      rdy_acc |= pready;
    end
    chk("abort_nopulse", 256'(acc), '0);
    chk("abort_noready", 256'(rdy_acc), '0);
    chk("abort_regq2", reg_q[2], '0);
    chk("abort_regq0", reg_q[0], m0);
    @(posedge PCLK); #1;
    psel[2] = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    xfer(2, 1, 12'h010, 32'h13579BDF, 0, 0, 4, "post_abort_wr");
    xfer(2, 0, 12'h010, 0, 32'h13579BDF, 0, 4, "post_abort_rd");

`ifdef APB_PSTRB_EN
    pstrb = 4'b0010;
    xfer(0, 1, 12'h014, 32'hAABBCCDD, 0, 0, 0, "strb_wr");
    @(negedge PCLK);
    chk("strb_pulse", 256'(reg_wr[0]), 256'(8'h20));
    @(posedge PCLK); #1;
    pstrb = 4'b0000;
    xfer(0, 0, 12'h014, 0, 32'h0000CC00, 0, 0, "strb_rd");
    pstrb = 4'hF;
`endif

    chk("sb_empty", 256'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
